// File: rtl/exu_pkg.sv
// Shared EXU writeback types: one buffered functional-unit result.
package exu_pkg;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              wen;
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO of writeback entries; head is visible combinationally
// from registered state so the arbiter can commit it in the same cycle.
module wb_fifo
  import exu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_entry_t     din_i,
  output logic          full_o,
  output logic          empty_o,
  output wb_entry_t     head_o,
  output logic [PW-1:0] count_o
);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          push_ok, pop_ok;
  wb_entry_t     mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  if (DEPTH > 1) begin : g_idx
    assign wr_idx = wr_q[IW-1:0];
    assign rd_idx = rd_q[IW-1:0];
  end else begin : g_idx_single
    assign wr_idx = '0;
    assign rd_idx = '0;
  end

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == PW'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_idx];

  assign wr_d = wr_q + PW'(push_ok);
  assign rd_d = rd_q + PW'(pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= din_i;
    end
  end
endmodule

// File: rtl/exu_wb_arbiter.sv
// EXU writeback arbiter: per-unit result FIFOs, round-robin selection of one
// head per cycle onto the GPR write port plus a completion pulse.
module exu_wb_arbiter #(
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 2,
  parameter int XLEN   = exu_pkg::XLEN,
  parameter int REG_AW = exu_pkg::REG_AW,
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PDW = $clog2(NUM_CH * DEPTH + 1),
  localparam int FCW = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        fu_vld,
  output logic [NUM_CH-1:0]        fu_rdy,
  input  logic [NUM_CH-1:0]        fu_wen,
  input  logic [NUM_CH*REG_AW-1:0] fu_addr,
  input  logic [NUM_CH*XLEN-1:0]   fu_data,
  output logic                     gpr_wen,
  output logic [REG_AW-1:0]        gpr_waddr,
  output logic [XLEN-1:0]          gpr_wdata,
  output logic                     commit_vld,
  output logic [CW-1:0]            commit_ch,
  output logic [PDW-1:0]           pending
);
  import exu_pkg::wb_entry_t;

  logic [NUM_CH-1:0] full, empty, push, pop;
  wb_entry_t         head       [NUM_CH];
  logic [FCW-1:0]    fifo_count [NUM_CH];

  logic          grant_vld;
  logic [CW-1:0] grant_ch;
  logic [CW-1:0] rr_q, rr_d;
  logic [PDW-1:0] pending_q, pending_d;
  wb_entry_t     sel;
  int            c;

  assign fu_rdy = ~full;
  assign push   = fu_vld & ~full;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    wb_entry_t din;
    assign din.wen  = fu_wen[gi];
    assign din.addr = fu_addr[gi*REG_AW +: REG_AW];
    assign din.data = fu_data[gi*XLEN +: XLEN];
    assign pop[gi]  = grant_vld && (grant_ch == CW'(gi));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[gi]),
      .pop_i   (pop[gi]),
      .din_i   (din),
      .full_o  (full[gi]),
      .empty_o (empty[gi]),
      .head_o  (head[gi]),
      .count_o (fifo_count[gi])
    );
  end

  // Scan channels starting at the RR pointer; first non-empty one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    c         = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(rr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!grant_vld && !empty[c]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'(c);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
    end
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pending_d = pending_d + PDW'(fifo_count[i]) + PDW'(push[i]);
    end
    pending_d = pending_d - PDW'(grant_vld);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= '0;
      pending_q <= '0;
    end else begin
      rr_q      <= rr_d;
      pending_q <= pending_d;
    end
  end

  // Writes to x0 still complete but never reach the register file.
  assign sel        = head[grant_ch];
  assign gpr_wen    = grant_vld & sel.wen & (|sel.addr);
  assign gpr_waddr  = gpr_wen ? sel.addr : '0;
  assign gpr_wdata  = gpr_wen ? sel.data : '0;
  assign commit_vld = grant_vld;
  assign commit_ch  = grant_vld ? grant_ch : '0;
  assign pending    = pending_q;
endmodule

// File: doc/exu_wb_arbiter.md
Name: exu_wb_arbiter

Overview:
- Parametrised writeback/completion arbiter for the EXU. It replaces the fixed-priority combinational ALU>LSU>CSR writeback mux.
- Accepts results from NUM_CH functional units (ALU, LSU, SYS, future MUL/DIV) over valid/ready handshakes and buffers each in a per-channel FIFO.
- Selects one result per cycle round-robin and drives the GPR write port plus a completion pulse that feeds ifetch_req.

Parameters:
- NUM_CH, 3, number of functional-unit writeback channels (>=1).
- DEPTH, 2, entries per channel FIFO (power of two, >=1).
- XLEN, 64, data width.
- REG_AW, 5, GPR address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fu_vld  in  NUM_CH  channel i presents a result
- fu_rdy  out  NUM_CH  channel i FIFO can accept
- fu_wen  in  NUM_CH  result writes GPR (0 = completion only: branch, store)
- fu_addr  in  NUM_CH*REG_AW  destination register, channel i at [i*REG_AW +: REG_AW]
- fu_data  in  NUM_CH*XLEN  result data, channel i at [i*XLEN +: XLEN]
- gpr_wen  out  1  GPR write enable
- gpr_waddr  out  REG_AW  GPR write address
- gpr_wdata  out  XLEN  GPR write data
- commit_vld  out  1  one instruction completes this cycle (drives ifetch_req)
- commit_ch  out  $clog2(NUM_CH) (min 1)  channel granted this cycle
- pending  out  $clog2(NUM_CH*DEPTH+1)  total buffered entries

Behaviour:
- Reset (async, rst_n=0):
  - All FIFOs empty; RR pointer = 0; pending = 0.
  - Outputs: gpr_wen=0, gpr_waddr=0, gpr_wdata=0, commit_vld=0, commit_ch=0, fu_rdy=all 1 once reset deasserts.
  - Reset mid-operation discards all buffered entries; no commit is issued for them.
- Push: on the rising edge where fu_vld[i] & fu_rdy[i], entry {wen, addr, data} is written to FIFO i.
  - fu_rdy[i] = !full[i]. It does not depend on a same-cycle pop (no pass-through when full).
  - fu_vld[i] while fu_rdy[i]=0: nothing is captured. The producer must hold its values stable until accepted.
- Latency: minimum 1 cycle. An entry pushed at edge N may commit in the cycle after edge N. There is no combinational bypass.
- Arbitration:
  - Among channels with non-empty FIFOs, grant the first at or after the RR pointer, modulo NUM_CH.
  - On a grant to channel g: pop FIFO g at the next edge and set the pointer to (g+1) mod NUM_CH.
  - With no requester, the pointer holds.
- Outputs from the granted head are combinational from registered FIFO state:
  - commit_vld = 1 and commit_ch = g.
  - gpr_wen = head.wen & (head.addr != 0).
  - gpr_waddr = head.addr, forced to 0 when gpr_wen = 0.
  - gpr_wdata = head.data, forced to 0 when gpr_wen = 0.
  - With no grant, all of these are 0.
- x0: a write to register 0 still produces commit_vld=1 but gpr_wen=0 and gpr_wdata=0.
- FIFO pointers wrap modulo DEPTH, with an extra wrap bit for full/empty.
- The same channel may push and pop in the same cycle when not full; occupancy is unchanged.
- pending = sum of FIFO occupancies, registered. It is updated at each edge by pushes minus at most one pop.
- Ordering: entries within one channel commit in FIFO order. There is no ordering guarantee across channels.

Decomposition:
- Package exu_pkg:
  - typedef wb_entry_t {logic wen; logic [REG_AW-1:0] addr; logic [XLEN-1:0] data;}.
  - Constants XLEN and REG_AW.
- Sub-module wb_fifo: single-clock FIFO for wb_entry_t, parameter DEPTH.
  - Ports: push, pop, full, empty, head, count.
  - Instantiated NUM_CH times by a generate loop.
- The arbiter (RR pointer plus masked priority find) stays in the top module.

Test Plan:
- Single write: ch0 pushes wen=1 addr=5 data=0xDEAD -> next cycle gpr_wen=1, gpr_waddr=5, gpr_wdata=0xDEAD, commit_vld=1, commit_ch=0; following cycle commit_vld=0, pending=0.
- x0 suppression: ch1 pushes wen=1 addr=0 data=0x1234 -> commit_vld=1, commit_ch=1, gpr_wen=0, gpr_wdata=0.
- Round-robin: RR pointer=0; ch0, ch1 and ch2 each push one entry in the same cycle -> commits on three consecutive cycles in order ch0, ch1, ch2. Then one entry each pushed into ch0 and ch2 -> order ch0, ch2.
- Backpressure: DEPTH=2; ch0 pushes 3 back-to-back while ch1 and ch2 are kept busy -> fu_rdy[0]=0 after two pushes; third entry held and accepted only after ch0's first pop; all three commit in push order.
- Completion only: ch2 pushes wen=0 addr=7 -> commit_vld=1, gpr_wen=0, gpr_waddr=0.
- Reset mid-operation: pending=4, then rst_n low for 1 cycle -> all outputs 0 immediately, pending=0, no commits after release, fu_rdy all 1.
